// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ABORT = 2'd2
  } pq_state_e;

  localparam logic [31:0] PQ_RESET_PC = 32'h0000_0000;
  localparam int          PQ_WADDR_W  = 30;
  localparam int          PQ_INST_W   = 32;

endpackage

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// Circular FIFO holding {pc, instruction} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Next pointer/count state; flush overrides any push or pop.
  always_comb begin
    do_push  = push && !flush && (count_q != FULL_CNT);
    do_pop   = pop && !flush && (count_q != (PW+1)'(0));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetcher: fetches sequential words from the I-cache into a queue,
// restarting on redirect and draining an in-flight request through ABORT.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = PQ_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ICACHE_ren,
  output logic                   ICACHE_wen,
  output logic [PQ_WADDR_W-1:0]  ICACHE_addr,
  output logic [31:0]            ICACHE_wdata,
  input  logic                   ICACHE_stall,
  input  logic [PQ_INST_W-1:0]   ICACHE_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [PQ_INST_W-1:0]   out_inst
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pq_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          push, pop, flush, done;

  // Request/valid derive only from registered state, never from inputs.
  always_comb begin
    ICACHE_ren = ((state_q == ST_FETCH) && (count < FULL_CNT)) || (state_q == ST_ABORT);
    out_valid  = (count != CW'(0));
  end

  // Next-state: sequential fetch, redirect handling, abort drain.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    flush        = redirect;
    done         = ICACHE_ren && !ICACHE_stall;
    pop          = out_valid && out_ready && !redirect;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect) fetch_pc_d = redirect_pc;
        else          fetch_pc_d = fetch_pc_q;
      end
      ST_FETCH: begin
        if (redirect) begin
          // An outstanding stalled request must finish before the new address goes out.
          if (ICACHE_ren && ICACHE_stall) begin
            state_d      = ST_ABORT;
            pending_pc_d = redirect_pc;
          end else begin
            fetch_pc_d   = redirect_pc;
          end
        end else if (done) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
      end
      ST_ABORT: begin
        if (redirect) pending_pc_d = redirect_pc;
        else          pending_pc_d = pending_pc_q;
        if (!ICACHE_stall) begin
          state_d    = ST_FETCH;
          fetch_pc_d = pending_pc_d;
        end else begin
          state_d    = ST_ABORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({fetch_pc_q, ICACHE_rdata}),
    .rdata (head),
    .count (count)
  );

  assign ICACHE_addr  = fetch_pc_q[31:2];
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = 32'h0000_0000;
  assign out_pc       = head[63:32];
  assign out_inst     = head[31:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised + directed bench for instr_prefetch_queue with a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_FETCH = 1, M_ABORT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ICACHE_ren, ICACHE_wen, ICACHE_stall;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata, ICACHE_rdata;
  logic        redirect, out_valid, out_ready;
  logic [31:0] redirect_pc, out_pc, out_inst;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [63:0] sb_q[$];
  int          mode;
  logic [31:0] mpc, mpend;
  bit          act_push, act_flush;
  logic [63:0] act_item;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen), .ICACHE_addr(ICACHE_addr),
    .ICACHE_wdata(ICACHE_wdata), .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Apply the model's predicted queue change at the clock edge.
  initial forever begin
    @(posedge clk);
    if (act_flush)     sb_q.delete();
    else if (act_push) sb_q.push_back(act_item);
    act_flush = 1'b0;
    act_push  = 1'b0;
  end

  // Monitor: compare the presented head against the scoreboard and pop on handshake.
  initial forever begin
    @(negedge clk);
    chk("out_valid", out_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      chk("out_pc", out_pc, sb_q[0][63:32]);
      chk("out_inst", out_inst, sb_q[0][31:0]);
      if (out_ready && !redirect && rst_n) void'(sb_q.pop_front());
    end
  end

  // One cycle: check request outputs, drive inputs, advance the model; called at posedge+1.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit exp_ren;
    exp_ren = (mode == M_FETCH && sb_q.size() < DEPTH) || mode == M_ABORT;
    chk("ren", ICACHE_ren, exp_ren);
    chk("addr", ICACHE_addr, mpc[31:2]);
    ICACHE_stall = st;
    redirect     = rd;
    redirect_pc  = rpc;
    out_ready    = rdy;
    ICACHE_rdata = exp_ren ? mem_word({ICACHE_addr, 2'b00}) : $urandom();
    case (mode)
      M_IDLE: begin
        mode = M_FETCH;
        if (rd) mpc = rpc;
      end
      M_FETCH: begin
        if (rd) begin
          act_flush = 1'b1;
          if (exp_ren && st) begin mode = M_ABORT; mpend = rpc; end
          else mpc = rpc;
        end else if (exp_ren && !st) begin
          act_push = 1'b1;
          act_item = {mpc, mem_word(mpc)};
          mpc      = mpc + 32'd4;
        end
      end
      default: begin
        if (rd) begin act_flush = 1'b1; mpend = rpc; end
        if (!st) begin mpc = mpend; mode = M_FETCH; end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; returns at posedge+1 with rst_n released.
  task automatic do_reset();
    rst_n = 1'b0;
    ICACHE_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    ICACHE_rdata = 32'h0;
    sb_q.delete();
    act_push = 1'b0; act_flush = 1'b0;
    mode = M_IDLE; mpc = 32'h0; mpend = 32'h0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ren", ICACHE_ren, 1'b0);
    chk("rst_addr", ICACHE_addr, 30'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go_to_addr8();
    int n;
    n = 0;
    while (mpc != 32'h8 && n < 20) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    chk("reach_addr8", ICACHE_addr, 30'h2);
  endtask

  initial begin
    do_reset();
    chk("wen", ICACHE_wen, 1'b0);
    chk("wdata", ICACHE_wdata, 32'h0);
    // streaming with a zero-wait cache
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    // fill with decode blocked, then release one entry
    do_reset();
    repeat (7) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_ren", ICACHE_ren, 1'b0);
    chk("full_addr", ICACHE_addr, 30'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("refill_ren", ICACHE_ren, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    // redirect during a stalled request
    do_reset();
    go_to_addr8();
    step(1'b1, 1'b1, 32'h100, 1'b1);
    chk("abort_hold1", ICACHE_addr, 30'h2);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("abort_hold2", ICACHE_addr, 30'h2);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("abort_resume", ICACHE_addr, 30'h40);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    // two redirects during abort: latest wins
    do_reset();
    go_to_addr8();
    step(1'b1, 1'b1, 32'h200, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("abort_latest", ICACHE_addr, 30'hC0);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    // redirect coinciding with completion and pop
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h480, 1'b1);
    chk("redir_empty", out_valid, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    // address wrap at the top of memory, then reset mid-stall
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", ICACHE_addr, 30'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    do_reset();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                        : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 7);
      if (i == 1500) begin #2; do_reset(); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
